sobel_window_gen: RTL and testbench

//  Raster-to-window stage directly upstream of sobel3x3det.
//  - Accepts one pixel per in_valid cycle in row-major order.
//  - Buffers two image lines and emits every full 3x3 neighbourhood as z1..z9.
//  - z5 (the centre pixel) is not produced, because sobel3x3det does not use it.
//  - Replaces the testbench-side cropping loop, so the edge path can run from a live stream.

---
 rtl/sobel_window_gen.sv | 112 +++++++++++
 tb/tb_sobel_window_gen.sv | 111 +++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - raster stream to 3x3 neighbourhood window generator (centre omitted)
module sobel_window_gen #(
    parameter int IMG_ROWS = 147,
    parameter int IMG_COLS = 143,
    parameter int PIX_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    output logic [PIX_W-1:0] z1,
    output logic [PIX_W-1:0] z2,
    output logic [PIX_W-1:0] z3,
    output logic [PIX_W-1:0] z4,
    output logic [PIX_W-1:0] z6,
    output logic [PIX_W-1:0] z7,
    output logic [PIX_W-1:0] z8,
    output logic [PIX_W-1:0] z9,
    output logic             out_valid,
    output logic             out_eol,
    output logic             out_eof,
    output logic             sof_err
);
    localparam int RW = $clog2(IMG_ROWS);
    localparam int CW = $clog2(IMG_COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_COLS - 1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nx;

    logic [RW-1:0]    row, pos_r;
    logic [CW-1:0]    col, pos_c;
    logic             accept, restart_err, emit, last_col, last_row;
    logic [PIX_W-1:0] lb0 [IMG_COLS];
    logic [PIX_W-1:0] lb1 [IMG_COLS];
    logic [PIX_W-1:0] top_rd, mid_rd;
    logic [PIX_W-1:0] top1, top2, mid1, mid2, bot1, bot2;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid && in_sof) state_nx = ACTIVE;
            ACTIVE:  if (accept && last_row && last_col) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // An in_sof pixel is always taken as (0,0), whatever the counters say.
    always_comb begin
        accept      = in_valid && (state == ACTIVE || in_sof);
        pos_r       = in_sof ? '0 : row;
        pos_c       = in_sof ? '0 : col;
        restart_err = accept && in_sof && (state == ACTIVE) && (row != '0 || col != '0);
        last_col    = (pos_c == COL_LAST);
        last_row    = (pos_r == ROW_LAST);
        emit        = accept && (pos_r >= ROW_TWO) && (pos_c >= COL_TWO);
        top_rd      = lb1[pos_c];
        mid_rd      = lb0[pos_c];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            col <= last_col ? '0 : pos_c + CW'(1);
            if (last_col) row <= last_row ? '0 : pos_r + RW'(1);
            else          row <= pos_r;
        end
    end

    // Line buffers are never cleared; the counter gate keeps stale lines out of windows.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[pos_c] <= mid_rd;
            lb0[pos_c] <= in_pixel;
            top2 <= top1;  top1 <= top_rd;
            mid2 <= mid1;  mid1 <= mid_rd;
            bot2 <= bot1;  bot1 <= in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            sof_err   <= 1'b0;
            z1 <= '0; z2 <= '0; z3 <= '0; z4 <= '0;
            z6 <= '0; z7 <= '0; z8 <= '0; z9 <= '0;
        end else begin
            out_valid <= emit;
            out_eol   <= emit && last_col;
            out_eof   <= emit && last_col && last_row;
            sof_err   <= restart_err;
            if (emit) begin
                z1 <= top2; z2 <= top1; z3 <= top_rd;
                z4 <= mid2;             z6 <= mid_rd;
                z7 <= bot2; z8 <= bot1; z9 <= in_pixel;
            end
        end
    end
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - randomized check of sobel_window_gen against an image-array model
module tb_sobel_window_gen;
    localparam int R = 5;
    localparam int C = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_pixel = 8'h00;
    logic [7:0] z1, z2, z3, z4, z6, z7, z8, z9;
    logic       out_valid, out_eol, out_eof, sof_err;

    sobel_window_gen #(.IMG_ROWS(R), .IMG_COLS(C), .PIX_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
        .z1(z1), .z2(z2), .z3(z3), .z4(z4), .z6(z6), .z7(z7), .z8(z8), .z9(z9),
        .out_valid(out_valid), .out_eol(out_eol), .out_eof(out_eof), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    bit         m_active = 0;
    int         m_row = 0;
    int         m_col = 0;
    logic [7:0] img [R][C];
    logic [63:0] e_z = '0;
    bit         e_valid, e_eol, e_eof, e_err;
    int         win_cnt, eof_cnt, err_cnt;

    task automatic step(input bit rst, input bit v, input bit s, input logic [7:0] p);
        @(negedge clk);
        reset = rst; in_valid = v; in_sof = s; in_pixel = p;
        e_valid = 0; e_eol = 0; e_eof = 0; e_err = 0;
        if (rst) begin
            m_active = 0; m_row = 0; m_col = 0; e_z = '0;
        end else if (v && (m_active || s)) begin
            if (s) begin
                if (m_active && (m_row != 0 || m_col != 0)) e_err = 1;
                m_row = 0; m_col = 0; m_active = 1;
            end
            img[m_row][m_col] = p;
            if (m_row >= 2 && m_col >= 2) begin
                e_valid = 1;
                e_z = {img[m_row-2][m_col-2], img[m_row-2][m_col-1], img[m_row-2][m_col],
                       img[m_row-1][m_col-2], img[m_row-1][m_col],
                       img[m_row][m_col-2], img[m_row][m_col-1], img[m_row][m_col]};
                e_eol = (m_col == C-1);
                e_eof = e_eol && (m_row == R-1);
            end
            if (m_col == C-1) begin
                m_col = 0;
                if (m_row == R-1) begin m_row = 0; m_active = 0; end
                else m_row++;
            end else m_col++;
        end
        @(posedge clk);
        #1;
        check("out_valid", 64'(out_valid), 64'(e_valid));
        check("out_eol", 64'(out_eol), 64'(e_eol));
        check("out_eof", 64'(out_eof), 64'(e_eof));
        check("sof_err", 64'(sof_err), 64'(e_err));
        check("window", {z1, z2, z3, z4, z6, z7, z8, z9}, e_z);
        win_cnt += int'(out_valid);
        eof_cnt += int'(out_eof);
        err_cnt += int'(sof_err);
    endtask

    initial begin
        step(1, 0, 0, 8'h00);
        step(1, 1, 1, 8'h55);
        // stray pixels before any start of frame must be dropped
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'(i + 8'hA0));

        // two back-to-back clean frames with random gaps
        win_cnt = 0; eof_cnt = 0; err_cnt = 0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < R*C; k++) begin
                step(0, 1, k == 0, 8'($urandom));
                if (f == 0 && ($urandom_range(0, 3) == 0)) step(0, 0, 0, 8'($urandom));
            end
        end
        step(0, 0, 0, 8'h00);
        check("frame_windows", 64'(win_cnt), 64'(2 * (R-2) * (C-2)));
        check("frame_eofs", 64'(eof_cnt), 64'd2);
        check("frame_sof_errs", 64'(err_cnt), 64'd0);

        // randomized stream: gaps, restarts, resets, dropped idle pixels
        for (int i = 0; i < 4000; i++) begin
            bit rst, v, s;
            rst = ($urandom_range(0, 199) == 0);
            v   = ($urandom_range(0, 3) != 0);
            if (m_row == 0 && m_col == 0) s = ($urandom_range(0, 4) != 0);
            else                          s = ($urandom_range(0, 59) == 0);
            step(rst, v, s, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
